// File: rtl/edge_result_packer.sv
// Circular set buffer that packs saved pixel sets into BUS_W words for the AHB write path.
// Optional EDGE_PACK_THRESH_EN: binarise each pixel against THRESH at capture.
module edge_result_packer #(
    parameter int NUM_PIX  = 9,
    parameter int PIX_W    = 8,
    parameter int BUS_W    = 32,
    parameter int NUM_SETS = 2,
    parameter int THRESH   = 128
) (
    input  logic                         clk,
    input  logic                         n_rst,
    input  logic [NUM_PIX*PIX_W-1:0]     i_pix,
    input  logic                         i_save,
    input  logic                         i_write_complete,
    output logic [BUS_W-1:0]             o_buffer2_data,
    output logic                         o_write_enable,
    output logic                         o_empty,
    output logic                         o_full,
    output logic                         o_overflow,
    output logic [$clog2(NUM_SETS+1)-1:0] o_set_count
);

    localparam int PPW    = BUS_W / PIX_W;
    localparam int WPS    = (NUM_PIX + PPW - 1) / PPW;
    localparam int SET_W  = NUM_PIX * PIX_W;
    localparam int PTR_W  = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1;
    localparam int CNT_W  = $clog2(NUM_SETS + 1);
    localparam int WIDX_W = (WPS > 1) ? $clog2(WPS) : 1;

    typedef enum logic {
        S_IDLE,
        S_REQ
    } state_t;

    state_t                r_state;
    logic [SET_W-1:0]      r_mem [NUM_SETS];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic [WIDX_W-1:0]     r_widx;
    logic [BUS_W-1:0]      r_data;
    logic                  r_we;
    logic                  r_empty;
    logic                  r_full;
    logic                  r_overflow;

    logic [SET_W-1:0]      w_cap;
    logic                  w_is_full;
    logic                  w_last;
    logic                  w_retire;
    logic                  w_accept;
    logic                  w_ovf;
    logic [CNT_W-1:0]      w_count_nxt;
    logic [PTR_W-1:0]      w_rd_nxt;

    function automatic logic [PTR_W-1:0] f_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(NUM_SETS - 1))
            return '0;
        return p + 1'b1;
    endfunction

    // Pixel k lands in word k/PPW, lane k%PPW; lanes past NUM_PIX stay zero.
    function automatic logic [BUS_W-1:0] f_word(input logic [SET_W-1:0] s, input int idx);
        logic [BUS_W-1:0] w;
        w = '0;
        for (int k = 0; k < NUM_PIX; k++) begin
            if (k / PPW == idx)
                w[(k % PPW)*PIX_W +: PIX_W] = s[k*PIX_W +: PIX_W];
        end
        return w;
    endfunction

`ifdef EDGE_PACK_THRESH_EN
    always_comb begin
        w_cap = '0;
        for (int k = 0; k < NUM_PIX; k++) begin
            w_cap[k*PIX_W +: PIX_W] =
                (i_pix[k*PIX_W +: PIX_W] >= PIX_W'(THRESH)) ? '1 : '0;
        end
    end
`else
    assign w_cap = i_pix;
`endif

    assign w_is_full   = (r_count == CNT_W'(NUM_SETS));
    assign w_last      = (int'(r_widx) == WPS - 1);
    assign w_retire    = (r_state == S_REQ) && i_write_complete && w_last;
    assign w_accept    = i_save && (!w_is_full || w_retire);
    assign w_ovf       = i_save && w_is_full && !w_retire;
    assign w_count_nxt = r_count + CNT_W'(w_accept) - CNT_W'(w_retire);
    assign w_rd_nxt    = f_inc(r_rd_ptr);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state    <= S_IDLE;
            for (int i = 0; i < NUM_SETS; i++)
                r_mem[i] <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_widx     <= '0;
            r_data     <= '0;
            r_we       <= 1'b0;
            r_empty    <= 1'b1;
            r_full     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_accept) begin
                r_mem[r_wr_ptr] <= w_cap;
                r_wr_ptr        <= f_inc(r_wr_ptr);
            end
            if (w_retire)
                r_rd_ptr <= w_rd_nxt;
            if (w_ovf)
                r_overflow <= 1'b1;
            r_count <= w_count_nxt;
            r_empty <= (w_count_nxt == '0);
            r_full  <= (w_count_nxt == CNT_W'(NUM_SETS));

            unique case (r_state)
                S_IDLE: begin
                    if (r_count != '0) begin
                        r_state <= S_REQ;
                        r_widx  <= '0;
                        r_we    <= 1'b1;
                        r_data  <= f_word(r_mem[r_rd_ptr], 0);
                    end
                end
                S_REQ: begin
                    if (i_write_complete) begin
                        if (!w_last) begin
                            r_widx <= r_widx + 1'b1;
                            r_data <= f_word(r_mem[r_rd_ptr], int'(r_widx) + 1);
                        end else begin
                            r_widx <= '0;
                            // A set saved in this same cycle is forwarded straight from the capture path.
                            if (r_count > CNT_W'(1)) begin
                                r_data <= f_word(r_mem[w_rd_nxt], 0);
                            end else if (w_accept) begin
                                r_data <= f_word(w_cap, 0);
                            end else begin
                                r_state <= S_IDLE;
                                r_we    <= 1'b0;
                            end
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_buffer2_data = r_data;
    assign o_write_enable = r_we;
    assign o_empty        = r_empty;
    assign o_full         = r_full;
    assign o_overflow     = r_overflow;
    assign o_set_count    = r_count;

endmodule

// File: tb/tb_edge_result_packer.sv
// Directed scoreboard bench for edge_result_packer (default parameters).
// Threshold step runs only when EDGE_PACK_THRESH_EN is defined.
module tb_edge_result_packer;

    logic        clk;
    logic        n_rst;
    logic [71:0] i_pix;
    logic        i_save;
    logic        i_write_complete;
    logic [31:0] o_buffer2_data;
    logic        o_write_enable;
    logic        o_empty;
    logic        o_full;
    logic        o_overflow;
    logic [1:0]  o_set_count;

    int          n_chk;
    int          n_err;
    logic [31:0] q[$];
    logic [31:0] last_word;

    edge_result_packer dut (
        .clk              (clk),
        .n_rst            (n_rst),
        .i_pix            (i_pix),
        .i_save           (i_save),
        .i_write_complete (i_write_complete),
        .o_buffer2_data   (o_buffer2_data),
        .o_write_enable   (o_write_enable),
        .o_empty          (o_empty),
        .o_full           (o_full),
        .o_overflow       (o_overflow),
        .o_set_count      (o_set_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [71:0] thr(input logic [71:0] p);
        logic [71:0] r;
        r = p;
`ifdef EDGE_PACK_THRESH_EN
        for (int k = 0; k < 9; k++)
            r[k*8 +: 8] = (p[k*8 +: 8] >= 8'd128) ? 8'hFF : 8'h00;
`endif
        return r;
    endfunction

    task automatic push_set(input logic [71:0] p);
        logic [71:0] t;
        t = thr(p);
        q.push_back(t[31:0]);
        q.push_back(t[63:32]);
        q.push_back({24'h0, t[71:64]});
    endtask

    task automatic wait_we(input string tag);
        int n;
        n = 0;
        while (!o_write_enable && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_we"}, o_write_enable, 1);
    endtask

    task automatic drain_word(input string tag);
        logic [31:0] exp;
        wait_we(tag);
        exp = (q.size() > 0) ? q.pop_front() : 32'hx;
        chk(tag, o_buffer2_data, exp);
        last_word = exp;
        i_write_complete = 1'b1;
        tick();
        i_write_complete = 1'b0;
    endtask

    task automatic save(input logic [71:0] p, input bit expect_store);
        i_pix  = p;
        i_save = 1'b1;
        if (expect_store)
            push_set(p);
        tick();
        i_save = 1'b0;
    endtask

    task automatic do_reset();
        n_rst = 1'b0;
        #3;
        n_rst = 1'b1;
        q.delete();
        tick();
    endtask

    logic [71:0] pa, pb, pc, pd, pe, pf, pg;

    initial begin
        n_chk = 0;
        n_err = 0;
        last_word = '0;
        n_rst = 1'b0;
        i_pix = '0;
        i_save = 1'b0;
        i_write_complete = 1'b0;
        pa = 72'h09_08_07_06_05_04_03_02_01;
        pb = {$urandom(), $urandom(), 8'h5A};
        pc = {$urandom(), $urandom(), 8'hC3};
        pd = 72'hDE_AD_BE_EF_01_23_45_67_89;
        pe = {$urandom(), $urandom(), 8'h3C};
        pf = {$urandom(), $urandom(), 8'h11};
        pg = {$urandom(), $urandom(), 8'h99};

        #12;
        chk("rst_we", o_write_enable, 0);
        chk("rst_empty", o_empty, 1);
        chk("rst_full", o_full, 0);
        chk("rst_ovf", o_overflow, 0);
        chk("rst_cnt", o_set_count, 0);
        chk("rst_data", o_buffer2_data, 0);
        n_rst = 1'b1;
        tick();

        // Single set with latency and packing.
        i_pix = pa;
        i_save = 1'b1;
`ifdef EDGE_PACK_THRESH_EN
        push_set(pa);
`else
        q.push_back(32'h04030201);
        q.push_back(32'h08070605);
        q.push_back(32'h00000009);
`endif
        tick();
        i_save = 1'b0;
        chk("t1_empty_t1", o_empty, 0);
        chk("t1_we_t1", o_write_enable, 0);
        tick();
        chk("t1_we_t2", o_write_enable, 1);
        for (int i = 0; i < 3; i++)
            drain_word("t1_word");
        chk("t1_we_done", o_write_enable, 0);
        chk("t1_empty_done", o_empty, 1);

        // Fill to full, then overflow.
        save(pb, 1);
        save(pc, 1);
        chk("t2_full", o_full, 1);
        chk("t2_cnt", o_set_count, 2);
        chk("t2_ovf0", o_overflow, 0);
        save(pd, 0);
        chk("t2_ovf", o_overflow, 1);
        chk("t2_cnt_ovf", o_set_count, 2);
        chk("t2_hold", o_buffer2_data, q[0]);
        for (int i = 0; i < 6; i++)
            drain_word("t2_word");
        chk("t2_empty", o_empty, 1);
        chk("t2_ovf_sticky", o_overflow, 1);

        // Save coinciding with retire while full.
        do_reset();
        chk("t3_ovf_clr", o_overflow, 0);
        save(pb, 1);
        save(pc, 1);
        drain_word("t3_b");
        drain_word("t3_b");
        wait_we("t3_b2");
        chk("t3_b2", o_buffer2_data, q.pop_front());
        i_pix = pe;
        i_save = 1'b1;
        i_write_complete = 1'b1;
        push_set(pe);
        tick();
        i_save = 1'b0;
        i_write_complete = 1'b0;
        chk("t3_nobubble", o_write_enable, 1);
        chk("t3_cnt", o_set_count, 2);
        chk("t3_full", o_full, 1);
        chk("t3_ovf", o_overflow, 0);
        for (int i = 0; i < 6; i++)
            drain_word("t3_word");
        chk("t3_empty", o_empty, 1);

        // Stray handshakes while empty.
        for (int i = 0; i < 3; i++) begin
            i_write_complete = 1'b1;
            tick();
            i_write_complete = 1'b0;
            tick();
        end
        chk("t4_we", o_write_enable, 0);
        chk("t4_empty", o_empty, 1);
        chk("t4_cnt", o_set_count, 0);
        chk("t4_data", o_buffer2_data, last_word);

        // Asynchronous reset during a request.
        save(pf, 1);
        wait_we("t5_pre");
        #2;
        n_rst = 1'b0;
        #1;
        chk("t5_we", o_write_enable, 0);
        chk("t5_empty", o_empty, 1);
        chk("t5_data", o_buffer2_data, 0);
        chk("t5_cnt", o_set_count, 0);
        tick();
        n_rst = 1'b1;
        q.delete();
        tick();
        save(pg, 1);
        for (int i = 0; i < 3; i++)
            drain_word("t5_word");
        chk("t5_empty_done", o_empty, 1);

`ifdef EDGE_PACK_THRESH_EN
        // Binarisation of boundary pixel values.
        i_pix = 72'h00_00_00_00_00_00_FF_80_7F;
        i_save = 1'b1;
        q.push_back(32'h00FFFF00);
        q.push_back(32'h00000000);
        q.push_back(32'h00000000);
        tick();
        i_save = 1'b0;
        for (int i = 0; i < 3; i++)
            drain_word("t6_word");
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
